mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the CPU core. Latches the MEM-stage result bundle and selects the write-back source: ALU result, load data, LUI immediate, or PC+4.
- Performs load byte/half extraction and sign or zero extension, and drives the register-file write port.
- Its registered outputs also serve as the WB forwarding source for the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, retire counter width (used only with the optional feature).

Ports:
- Clock  in  1  system clock, all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ClockEnable  in  1  pipeline advance; 0 = stall and hold all state.
- Flush  in  1  insert a bubble into WB.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_we  in  1  instruction writes rd.
- mem_rd  in  REG_ADDR_W  destination register.
- mem_wb_sel  in  2  source select: 00 ALU, 01 load, 10 LUI immediate, 11 PC+4.
- mem_ld_funct  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_addr_lo  in  2  load address bits [1:0].
- mem_alu  in  XLEN  ALU result.
- mem_rdata  in  XLEN  raw aligned data-memory word.
- mem_lui_imm  in  XLEN  immediate already shifted (imm<<12).
- mem_pc4  in  XLEN  PC+4.
- wb_valid  out  1  WB holds a real instruction.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- misalign_err  out  1  latched load is misaligned.

Behaviour:
- Interface (already decided): one clock, Clock. Reset_n is asynchronous and active-low.
- Reset: while Reset_n=0, all latched fields clear to 0. Consequently wb_valid, rf_we, rf_waddr, rf_wdata and misalign_err are all 0.
- Register update priority on each rising Clock edge:
  - Flush=1: wb_valid<=0. This applies regardless of ClockEnable. Other fields are don't-care but are held.
  - Else ClockEnable=1: capture every mem_* field. wb_valid<=mem_valid.
  - Else (stall): hold all state.
- Latency: exactly one cycle from MEM inputs to WB outputs. All WB outputs are combinational from the latched fields only; no mem_* input reaches an output combinationally.
- rf_waddr = latched rd.
- rf_we = wb_valid & reg_we & (rd!=0) & !misalign_err. Writes to x0 are never issued.
- During a stall, rf_we stays asserted with identical address and data. The resulting repeated register-file write is idempotent and is legal.
- Load extraction (wb_sel=01):
  - Byte lane = addr_lo. Half lane = addr_lo[1].
  - LB: sign-extend byte. LBU: zero-extend byte. LH: sign-extend half. LHU: zero-extend half. LW: full word.
  - funct3 values 011, 110, 111 are treated as LW.
- Misalignment: misalign_err = wb_valid & wb_sel==01 & (halfword load with addr_lo[0]=1, or word load with addr_lo!=0).
  - misalign_err suppresses rf_we.
  - It is level, not sticky: it clears when the next instruction is latched.
- rf_wdata for the other selects: wb_sel=10 gives lui_imm unchanged, 11 gives pc4, 00 gives alu.
- Output widths are exactly XLEN. There is no truncation, since every source is XLEN wide.
- When wb_valid=0, rf_wdata may be any value, but rf_we must be 0.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output port retire_cnt (CNT_W bits).
  - The counter increments by 1 on each rising edge where ClockEnable=1 and wb_valid=1. Retirement counts once per advance, not per stall cycle.
  - Flushed bubbles are not counted.
  - The counter wraps from all-ones to 0.
  - Reset_n=0 clears it.
- When undefined: no port and no counter logic.

Test Plan:
- Reset: assert Reset_n=0 mid-run while wb_valid=1 → rf_we, wb_valid and rf_wdata go to 0 immediately, without waiting for a clock edge.
- LUI: rd=5, sel=10, lui_imm=0x12345000, mem_valid=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345000.
- Load extraction: rdata=0x80FF7F01.
  - LB at addr_lo=3 → 0xFFFFFF80.
  - LBU at addr_lo=1 → 0x0000007F.
  - LH at addr_lo=2 → 0xFFFF80FF.
  - LHU at addr_lo=0 → 0x00007F01.
- Misalignment and x0:
  - LW at addr_lo=2, rd=7 → misalign_err=1, rf_we=0.
  - ALU write to rd=0, alu=0xDEADBEEF → rf_we=0.
- Stall and flush:
  - ClockEnable=0 for 3 cycles with a PC+4 result pending → outputs are held constant.
  - Flush=1 with ClockEnable=0 → wb_valid=0 on the next edge.
- Retire counter (WB_RETIRE_CNT_EN defined):
  - 4 valid advances, 2 stall cycles and 1 flushed bubble → retire_cnt=4.
  - Preload near all-ones via back-to-back retires → counter wraps to 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: latches the MEM result bundle, extracts and extends load data,
// and drives the register-file write port. Define WB_RETIRE_CNT_EN to add the retire counter.
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  ClockEnable,
  input  logic                  Flush,
  input  logic                  mem_valid,
  input  logic                  mem_reg_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_ld_funct,
  input  logic [1:0]            mem_addr_lo,
  input  logic [XLEN-1:0]       mem_alu,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       mem_lui_imm,
  input  logic [XLEN-1:0]       mem_pc4,
  output logic                  wb_valid,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  misalign_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      retire_cnt
`endif
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LUI  = 2'b10,
    WB_PC4  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  logic                  valid_q;
  logic                  reg_we_q;
  logic [REG_ADDR_W-1:0] rd_q;
  wb_sel_e               wb_sel_q;
  logic [2:0]            ld_funct_q;
  logic [1:0]            addr_lo_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       rdata_q;
  logic [XLEN-1:0]       lui_imm_q;
  logic [XLEN-1:0]       pc4_q;

  // Flush only kills the valid bit; the payload is simply held so a flush never
  // disturbs forwarding data that the hazard unit may still be comparing against.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      valid_q <= 1'b0;
    end else if (Flush) begin
      valid_q <= 1'b0;
    end else if (ClockEnable) begin
      valid_q <= mem_valid;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      reg_we_q   <= 1'b0;
      rd_q       <= '0;
      wb_sel_q   <= WB_ALU;
      ld_funct_q <= '0;
      addr_lo_q  <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      lui_imm_q  <= '0;
      pc4_q      <= '0;
    end else if (ClockEnable && !Flush) begin
      reg_we_q   <= mem_reg_we;
      rd_q       <= mem_rd;
      wb_sel_q   <= wb_sel_e'(mem_wb_sel);
      ld_funct_q <= mem_ld_funct;
      addr_lo_q  <= mem_addr_lo;
      alu_q      <= mem_alu;
      rdata_q    <= mem_rdata;
      lui_imm_q  <= mem_lui_imm;
      pc4_q      <= mem_pc4;
    end
  end

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic            is_byte;
  logic            is_half;
  logic [XLEN-1:0] load_data;

  assign byte_lane = byte_lane_of(rdata_q, addr_lo_q);
  assign half_lane = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign is_byte   = (ld_funct_q == F_LB) || (ld_funct_q == F_LBU);
  assign is_half   = (ld_funct_q == F_LH) || (ld_funct_q == F_LHU);

  function automatic logic [7:0] byte_lane_of(input logic [XLEN-1:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Reserved funct3 encodings fall into the default arm and load the full word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_data = rdata_q;
    case (ld_funct_q)
      F_LB:    load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F_LBU:   load_data = {{(XLEN-8){1'b0}}, byte_lane};
      F_LH:    load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F_LHU:   load_data = {{(XLEN-16){1'b0}}, half_lane};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    rf_wdata = alu_q;
    case (wb_sel_q)
      WB_ALU:  rf_wdata = alu_q;
      WB_LOAD: rf_wdata = load_data;
      WB_LUI:  rf_wdata = lui_imm_q;
      WB_PC4:  rf_wdata = pc4_q;
      default: rf_wdata = alu_q;
    endcase
  end

  // Byte loads can never be misaligned; every non-byte, non-half encoding is a word load.
  assign misalign_err = valid_q && (wb_sel_q == WB_LOAD) &&
                        ((is_half && addr_lo_q[0]) ||
                         (!is_half && !is_byte && (addr_lo_q != 2'b00)));

  assign wb_valid = valid_q;
  assign rf_waddr = rd_q;
  assign rf_we    = valid_q && reg_we_q && (rd_q != '0) && !misalign_err;

`ifdef WB_RETIRE_CNT_EN
  // Counts the instruction leaving WB on each advance; stalls and bubbles do not count.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      retire_cnt <= '0;
    end else if (ClockEnable && valid_q) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
